// File: rtl/microcode_dispatcher_if.sv
// Fetch/microcode-side bundle of the microcode dispatcher: instruction handshake,
// sos/eos segment handshake and status outputs.
interface microcode_dispatcher_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [5:0]         opcode;
  logic               sos;
  logic               eos;
  logic               busy;
  logic               halted;
  logic               timeout_err;
  logic [CNT_W-1:0]   retired;

  // master: fetch unit plus microcode sequencer; slave: the dispatcher
  modport master (
    output instr_valid, instr, eos,
    input  instr_ready, opcode, sos, busy, halted, timeout_err, retired
  );

  modport slave (
    input  instr_valid, instr, eos,
    output instr_ready, opcode, sos, busy, halted, timeout_err, retired
  );
endinterface

// File: rtl/microcode_dispatcher.sv
// Issue side of the sos/eos segment handshake: takes one instruction at a time,
// pulses sos, waits for a stable eos terminator, and flags halt or hung segments.
module microcode_dispatcher #(
  parameter int INSTR_W    = 32,
  parameter int OPCODE_LSB = 26,
  parameter int EOS_STABLE = 2,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  microcode_dispatcher_if.slave  bus
);

  localparam int         EC_W    = $clog2(EOS_STABLE + 1);
  localparam int         TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [5:0] HALT_OP = 6'h3F;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_RUN, S_HALT, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [5:0]        opcode_q, opcode_d;
  logic              sos_q, sos_d;
  logic              instr_ready_q, instr_ready_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [EC_W-1:0]   eos_cnt_q, eos_cnt_d;
  logic [TO_W-1:0]   run_cnt_q, run_cnt_d;
  logic [5:0]        op_in;

  assign op_in = bus.instr[OPCODE_LSB +: 6];

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    sos_d         = 1'b0;
    halted_d      = halted_q;
    timeout_err_d = timeout_err_q;
    retired_d     = retired_q;
    eos_cnt_d     = eos_cnt_q;
    run_cnt_d     = run_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && instr_ready_q) begin
          opcode_d = op_in;
          if (op_in == HALT_OP) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            sos_d   = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        // eos may still carry the previous segment's terminator here, so it is not counted
        eos_cnt_d = '0;
        run_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + TO_W'(1);
        if (bus.eos)
          eos_cnt_d = (eos_cnt_q == '1) ? eos_cnt_q : eos_cnt_q + EC_W'(1);
        else
          eos_cnt_d = '0;
        // completion is tested first so it wins a tie with the timeout
        if (eos_cnt_d == EC_W'(EOS_STABLE)) begin
          state_d   = S_IDLE;
          retired_d = retired_q + CNT_W'(1);
        end else if ((TIMEOUT != 0) && (run_cnt_d == TO_W'(TIMEOUT))) begin
          state_d       = S_ERR;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase

    instr_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d == S_ISSUE) || (state_d == S_ARM) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      opcode_q      <= 6'h00;
      sos_q         <= 1'b0;
      instr_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      retired_q     <= '0;
      eos_cnt_q     <= '0;
      run_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      sos_q         <= sos_d;
      instr_ready_q <= instr_ready_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
      retired_q     <= retired_d;
      eos_cnt_q     <= eos_cnt_d;
      run_cnt_q     <= run_cnt_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.opcode      = opcode_q;
  assign bus.sos         = sos_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_microcode_dispatcher.sv
// Bench for microcode_dispatcher: expected opcodes are queued at each handshake and
// popped when sos appears; a second instance with a 2-bit retired counter shares stimulus.
module tb_microcode_dispatcher;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   model_ret = 0;
  int   sos_count = 0;
  logic [5:0] exp_q[$];

  microcode_dispatcher_if #(.INSTR_W(32), .CNT_W(16)) bus ();
  microcode_dispatcher_if #(.INSTR_W(32), .CNT_W(2))  bus_w ();

  assign bus_w.instr_valid = bus.instr_valid;
  assign bus_w.instr       = bus.instr;
  assign bus_w.eos         = bus.eos;

  microcode_dispatcher #(.TIMEOUT(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  microcode_dispatcher #(.TIMEOUT(8), .CNT_W(2)) u_dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string tag);
    check({tag, "_retired"}, 32'(bus.retired), 32'(model_ret % 65536));
    check({tag, "_retired_w"}, 32'(bus_w.retired), 32'(model_ret % 4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.eos = 1'b0;
    tick();
    model_ret = 0;
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sos", 32'(bus.sos), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'h00);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    check_ret("rst");
    rst = 1'b0;
    tick();
    check("rst_ready_after", 32'(bus.instr_ready), 32'd1);
  endtask

  // Present a word and complete the handshake; returns in the cycle after acceptance
  task automatic send(input logic [5:0] op, input logic keep_valid);
    logic [31:0] w;
    int waited;
    w = $urandom;
    w[31:26] = op;
    bus.instr = w;
    bus.instr_valid = 1'b1;
    waited = 0;
    while (!bus.instr_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("ready_wait", 32'(bus.instr_ready), 32'd1);
    if (op != 6'h3F) exp_q.push_back(op);
    tick();
    if (!keep_valid) bus.instr_valid = 1'b0;
  endtask

  // Full segment: eos follows pat (MSB first) over n RUN cycles; must complete on the last
  task automatic seg(input logic [5:0] op, input logic [15:0] pat, input int n, input logic arm_eos);
    send(op, 1'b0);
    check("issue_sos", 32'(bus.sos), 32'd1);
    check("issue_busy", 32'(bus.busy), 32'd1);
    check("issue_opcode", 32'(bus.opcode), 32'(op));
    bus.eos = arm_eos;
    tick();
    check("arm_sos", 32'(bus.sos), 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      bus.eos = pat[n-1-i];
      tick();
      if (i < n - 1) begin
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_ready", 32'(bus.instr_ready), 32'd0);
      end
    end
    bus.eos = 1'b0;
    model_ret++;
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_ready", 32'(bus.instr_ready), 32'd1);
    check("done_opcode", 32'(bus.opcode), 32'(op));
    check_ret("done");
  endtask

  // Scoreboard consumer: every sos must match the oldest accepted non-halt opcode
  initial begin
    logic sos_prev;
    logic [5:0] exp_op;
    sos_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.sos) begin
        sos_count++;
        check("sos_one_cycle", 32'(sos_prev), 32'd0);
        check("sos_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_op = exp_q.pop_front();
          check("sos_opcode", 32'(bus.opcode), 32'(exp_op));
        end
      end
      sos_prev = bus.sos;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [4];
    logic [31:0] w;
    int base;
    ops = '{6'h01, 6'h22, 6'h0A, 6'h15};
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.eos = 1'b0;
    tick();
    do_reset();

    // basic segment: eos 0,0,0 then held high
    seg(6'h05, 16'b00011, 5, 1'b0);
    // nested returns; eos high during ISSUE/ARM must not be counted
    seg(6'h12, 16'b1001011, 7, 1'b1);
    // completion on the same cycle the timeout would fire
    seg(6'h2C, 16'b00000011, 8, 1'b0);

    // back-to-back with instr_valid held high
    base = sos_count;
    for (int k = 0; k < 4; k++) begin
      send(ops[k], 1'b1);
      w = $urandom;
      w[31:26] = ops[(k + 1) % 4];
      bus.instr = w;
      check("b2b_ready", 32'(bus.instr_ready), 32'd0);
      tick();
      tick();
      bus.eos = 1'b1;
      tick();
      check("b2b_opcode", 32'(bus.opcode), 32'(ops[k]));
      tick();
      bus.eos = 1'b0;
      model_ret++;
      check("b2b_busy", 32'(bus.busy), 32'd0);
      if (k == 3) bus.instr_valid = 1'b0;
    end
    check("b2b_sos_count", 32'(sos_count - base), 32'd4);
    check_ret("b2b");

    // halt
    send(6'h3F, 1'b1);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_busy", 32'(bus.busy), 32'd0);
    check("halt_opcode", 32'(bus.opcode), 32'h3F);
    check_ret("halt");
    w = $urandom;
    w[31:26] = 6'h05;
    bus.instr = w;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_ready", 32'(bus.instr_ready), 32'd0);
      check("halt_sticky", 32'(bus.halted), 32'd1);
    end
    bus.instr_valid = 1'b0;
    do_reset();

    // timeout with eos held low
    send(6'h07, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) check("to_busy_run", 32'(bus.busy), 32'd1);
      if (i < 7) check("to_not_yet", 32'(bus.timeout_err), 32'd0);
    end
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd0);
    check("to_ready", 32'(bus.instr_ready), 32'd0);
    bus.instr_valid = 1'b1;
    tick();
    tick();
    check("to_ready_held", 32'(bus.instr_ready), 32'd0);
    check("to_sticky", 32'(bus.timeout_err), 32'd1);
    do_reset();

    // reset in the middle of RUN
    send(6'h09, 1'b0);
    tick();
    tick();
    tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    model_ret = 0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sos", 32'(bus.sos), 32'd0);
    check("mid_rst_opcode", 32'(bus.opcode), 32'h00);
    check_ret("mid_rst");
    rst = 1'b0;
    tick();
    check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);

    // retired wrap on the 2-bit instance
    for (int k = 0; k < 5; k++) seg(6'(k + 3), 16'b11, 2, 1'b0);
    check("wrap_retired_w", 32'(bus_w.retired), 32'd1);
    check("wrap_retired", 32'(bus.retired), 32'd5);

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
